// File: rtl/memory_read_if.sv
// Bus bundle between memory_read, its command RAM and the line drawer.
// With MEMORY_READ_BLANK_MOVE_EN defined the bundle also carries the blank flag.
interface memory_read_if #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DATAWIDTH = 18
);
  logic                 go;
  logic [DATAWIDTH-1:0] dataRAM;
  logic [ADR_WIDTH-1:0] adrRAM;
  logic [OUT_WIDTH-1:0] x0;
  logic [OUT_WIDTH-1:0] y0;
  logic [OUT_WIDTH-1:0] x1;
  logic [OUT_WIDTH-1:0] y1;
  logic                 start;
  logic                 done;
  logic                 halt;
  logic                 frame_done;
  logic                 overrun;
`ifdef MEMORY_READ_BLANK_MOVE_EN
  logic                 blank;
`endif

  modport master (
    input  go, dataRAM, done,
    output adrRAM, x0, y0, x1, y1, start, halt, frame_done, overrun
`ifdef MEMORY_READ_BLANK_MOVE_EN
    , output blank
`endif
  );

  modport slave (
    output go, dataRAM, done,
    input  adrRAM, x0, y0, x1, y1, start, halt, frame_done, overrun
`ifdef MEMORY_READ_BLANK_MOVE_EN
    , input blank
`endif
  );
endinterface

// File: rtl/memory_read.sv
// Walks a vector command list in RAM and feeds line segments to a line drawer.
// Optional MEMORY_READ_BLANK_MOVE_EN: moves are reported to the drawer with blank=1.
module memory_read #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DATAWIDTH = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_read_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, DRAW, WAIT_LINE, FRAME_END
  } state_t;

  state_t               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [OUT_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [OUT_WIDTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                 overrun_q, overrun_d;
`ifdef MEMORY_READ_BLANK_MOVE_EN
  logic                 blank_q, blank_d;
`endif

  logic [OUT_WIDTH-1:0] entry_x, entry_y;
  logic [1:0]           entry_kind;
  logic                 adr_last;

  assign entry_x    = bus.dataRAM[2+2*OUT_WIDTH-1 -: OUT_WIDTH];
  assign entry_y    = bus.dataRAM[2+OUT_WIDTH-1 -: OUT_WIDTH];
  assign entry_kind = bus.dataRAM[1:0];
  assign adr_last   = (adr_q == '1);

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    overrun_d = overrun_q;
`ifdef MEMORY_READ_BLANK_MOVE_EN
    blank_d   = blank_q;
`endif
    unique case (state_q)
      IDLE: begin
        adr_d = '0;
        if (bus.go) state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        unique case (entry_kind)
          2'b01: begin
            cur_x_d = entry_x;
            cur_y_d = entry_y;
`ifdef MEMORY_READ_BLANK_MOVE_EN
            x0_d    = cur_x_q;
            y0_d    = cur_y_q;
            x1_d    = entry_x;
            y1_d    = entry_y;
            blank_d = 1'b1;
            state_d = DRAW;
`else
            // Advancing past the top address ends the frame rather than wrapping.
            if (adr_last) begin
              overrun_d = 1'b1;
              state_d   = FRAME_END;
            end else begin
              adr_d   = adr_q + ADR_WIDTH'(1);
              state_d = FETCH;
            end
`endif
          end
          2'b10: begin
            x0_d    = cur_x_q;
            y0_d    = cur_y_q;
            x1_d    = entry_x;
            y1_d    = entry_y;
            cur_x_d = entry_x;
            cur_y_d = entry_y;
`ifdef MEMORY_READ_BLANK_MOVE_EN
            blank_d = 1'b0;
`endif
            state_d = DRAW;
          end
          2'b00: begin
            x0_d    = entry_x;
            y0_d    = entry_y;
            x1_d    = entry_x;
            y1_d    = entry_y;
            cur_x_d = entry_x;
            cur_y_d = entry_y;
`ifdef MEMORY_READ_BLANK_MOVE_EN
            blank_d = 1'b0;
`endif
            state_d = DRAW;
          end
          2'b11: state_d = FRAME_END;
        endcase
      end
      DRAW: state_d = WAIT_LINE;
      WAIT_LINE: begin
        if (bus.done) begin
          if (adr_last) begin
            overrun_d = 1'b1;
            state_d   = FRAME_END;
          end else begin
            adr_d   = adr_q + ADR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      FRAME_END: begin
        adr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      overrun_q <= 1'b0;
`ifdef MEMORY_READ_BLANK_MOVE_EN
      blank_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      overrun_q <= overrun_d;
`ifdef MEMORY_READ_BLANK_MOVE_EN
      blank_q   <= blank_d;
`endif
    end
  end

  // Pulses decode straight from the state register so reset removes them at once.
  assign bus.adrRAM     = adr_q;
  assign bus.x0         = x0_q;
  assign bus.y0         = y0_q;
  assign bus.x1         = x1_q;
  assign bus.y1         = y1_q;
  assign bus.start      = (state_q == DRAW);
  assign bus.frame_done = (state_q == FRAME_END);
  assign bus.halt       = (state_q == FETCH) || (state_q == DECODE) ||
                          (state_q == DRAW)  || (state_q == WAIT_LINE);
  assign bus.overrun    = overrun_q;
`ifdef MEMORY_READ_BLANK_MOVE_EN
  assign bus.blank      = blank_q;
`endif

endmodule

// File: tb/tb_memory_read.sv
// Directed bench for memory_read: one 16-bit-address instance plus a 4-bit-address
// instance for the overrun case. Blank-move checks build with MEMORY_READ_BLANK_MOVE_EN.
module tb_memory_read;

  localparam logic [1:0] K_MOVE = 2'b01;
  localparam logic [1:0] K_LINE = 2'b10;
  localparam logic [1:0] K_PNT  = 2'b00;
  localparam logic [1:0] K_END  = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  memory_read_if #(.OUT_WIDTH(8), .ADR_WIDTH(16), .DATAWIDTH(18)) bus ();
  memory_read_if #(.OUT_WIDTH(8), .ADR_WIDTH(4),  .DATAWIDTH(18)) bus2 ();

  memory_read #(.OUT_WIDTH(8), .ADR_WIDTH(16), .DATAWIDTH(18)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  memory_read #(.OUT_WIDTH(8), .ADR_WIDTH(4), .DATAWIDTH(18)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] mem  [0:15];
  logic [17:0] mem2 [0:15];

  // Registered RAM: data follows the address by one cycle.
  always @(posedge clk) begin
    bus.dataRAM  <= mem[bus.adrRAM[3:0]];
    bus2.dataRAM <= mem2[bus2.adrRAM];
  end

  logic drawer_en  = 1'b1;
  logic done_auto  = 1'b0;
  logic done_force = 1'b0;
  logic done2      = 1'b0;
  int   dcnt       = 0;
  assign bus.done  = done_auto | done_force;
  assign bus2.done = done2;

  always @(posedge clk) begin
    done_auto <= 1'b0;
    if (!drawer_en) dcnt <= 0;
    else if (bus.start) dcnt <= 5;
    else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_auto <= 1'b1;
    end
  end

  logic draw_pulse;
`ifdef MEMORY_READ_BLANK_MOVE_EN
  assign draw_pulse = bus.start & ~bus.blank;
`else
  assign draw_pulse = bus.start;
`endif

  int start_cnt = 0;
  always @(posedge clk) if (draw_pulse) start_cnt <= start_cnt + 1;

  function automatic logic [17:0] ent(input logic [7:0] x, input logic [7:0] y, input logic [1:0] k);
    return {x, y, k};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = ent(8'd0, 8'd0, K_END);
  endtask

  task automatic wait_draw(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (draw_pulse) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus2.go = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", bus.start); end
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b expected 0", bus.halt); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", bus.frame_done); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", bus.overrun); end
    checks++; if (bus.adrRAM !== 16'd0) begin errors++; $display("FAIL rst_adr: got %0d expected 0", bus.adrRAM); end
    checks++; if ({bus.x0, bus.y0, bus.x1, bus.y1} !== 32'd0) begin errors++; $display("FAIL rst_coords: got %h expected 0", {bus.x0, bus.y0, bus.x1, bus.y1}); end
    checks++; if (bus2.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun2: got %b expected 0", bus2.overrun); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL idle_halt: got %b expected 0", bus.halt); end
  endtask

  task automatic test_line();
    bit ok; int n0;
    clear_mem();
    mem[0] = ent(8'd0, 8'd0, K_MOVE);
    mem[1] = ent(8'd10, 8'd20, K_LINE);
    n0 = start_cnt;
    bus.go = 1'b1;
    wait_draw(ok);
    bus.go = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL line_start: got timeout expected start"); end
    checks++; if ({bus.x0, bus.y0} !== {8'd0, 8'd0}) begin errors++; $display("FAIL line_p0: got %0d,%0d expected 0,0", bus.x0, bus.y0); end
    checks++; if ({bus.x1, bus.y1} !== {8'd10, 8'd20}) begin errors++; $display("FAIL line_p1: got %0d,%0d expected 10,20", bus.x1, bus.y1); end
    checks++; if (bus.adrRAM !== 16'd1) begin errors++; $display("FAIL line_adr: got %0d expected 1", bus.adrRAM); end
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL line_halt: got %b expected 1", bus.halt); end
    @(posedge clk); #1;
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL line_start_width: got %b expected 0", bus.start); end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL line_frame: got timeout expected frame_done"); end
    checks++; if (bus.adrRAM !== 16'd2) begin errors++; $display("FAIL line_end_adr: got %0d expected 2", bus.adrRAM); end
    checks++; if (start_cnt - n0 !== 1) begin errors++; $display("FAIL line_count: got %0d expected 1", start_cnt - n0); end
    @(posedge clk); #1;
    checks++; if (bus.adrRAM !== 16'd0) begin errors++; $display("FAIL line_adr_back: got %0d expected 0", bus.adrRAM); end
    checks++; if (bus.frame_done !== 1'b0 || bus.halt !== 1'b0) begin errors++; $display("FAIL line_idle: got fd=%b halt=%b expected 0,0", bus.frame_done, bus.halt); end
  endtask

  task automatic test_point();
    bit ok;
    clear_mem();
    mem[0] = ent(8'd3, 8'd3, K_MOVE);
    mem[1] = ent(8'd7, 8'd7, K_PNT);
    mem[2] = ent(8'd9, 8'd1, K_LINE);
    bus.go = 1'b1;
    wait_draw(ok);
    bus.go = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL point_start: got timeout expected start"); end
    checks++; if ({bus.x0, bus.y0, bus.x1, bus.y1} !== {8'd7, 8'd7, 8'd7, 8'd7}) begin errors++; $display("FAIL point_coords: got %0d,%0d,%0d,%0d expected 7,7,7,7", bus.x0, bus.y0, bus.x1, bus.y1); end
    wait_draw(ok);
    checks++; if ({bus.x0, bus.y0} !== {8'd7, 8'd7}) begin errors++; $display("FAIL point_cur: got %0d,%0d expected 7,7", bus.x0, bus.y0); end
    checks++; if ({bus.x1, bus.y1} !== {8'd9, 8'd1}) begin errors++; $display("FAIL point_next_p1: got %0d,%0d expected 9,1", bus.x1, bus.y1); end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL point_frame: got timeout expected frame_done"); end
  endtask

  task automatic test_done_ignored();
    bit ok;
    drawer_en = 1'b0;
    clear_mem();
    mem[0] = ent(8'd1, 8'd1, K_LINE);
    @(posedge clk); #1 done_force = 1'b1;
    @(posedge clk); #1 done_force = 1'b0;
    checks++; if (bus.halt !== 1'b0 || bus.adrRAM !== 16'd0) begin errors++; $display("FAIL done_idle: got halt=%b adr=%0d expected 0,0", bus.halt, bus.adrRAM); end
    bus.go = 1'b1;
    wait_draw(ok);
    bus.go = 1'b0;
    done_force = 1'b1;
    @(posedge clk); #1 done_force = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.halt !== 1'b1 || bus.adrRAM !== 16'd0) begin errors++; $display("FAIL done_in_draw: got halt=%b adr=%0d expected 1,0", bus.halt, bus.adrRAM); end
    done_force = 1'b1;
    @(posedge clk); #1 done_force = 1'b0;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL done_frame: got timeout expected frame_done"); end
    drawer_en = 1'b1;
  endtask

  task automatic test_go_drop();
    bit ok; int n0;
    clear_mem();
    mem[0] = ent(8'd1, 8'd2, K_LINE);
    mem[1] = ent(8'd3, 8'd4, K_LINE);
    mem[2] = ent(8'd5, 8'd6, K_PNT);
    mem[3] = ent(8'd7, 8'd8, K_LINE);
    n0 = start_cnt;
    bus.go = 1'b1;
    wait_draw(ok);
    wait_draw(ok);
    checks++; if (bus.x1 !== 8'd3) begin errors++; $display("FAIL drop_entry1: got %0d expected 3", bus.x1); end
    @(posedge clk); #1 bus.go = 1'b0;
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_frame: got timeout expected frame_done"); end
    checks++; if (start_cnt - n0 !== 4) begin errors++; $display("FAIL drop_count: got %0d expected 4", start_cnt - n0); end
    checks++; if ({bus.x1, bus.y1} !== {8'd7, 8'd8}) begin errors++; $display("FAIL drop_last: got %0d,%0d expected 7,8", bus.x1, bus.y1); end
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (bus.halt !== 1'b0 || start_cnt - n0 !== 4) begin errors++; $display("FAIL drop_idle: got halt=%b count=%0d expected 0,4", bus.halt, start_cnt - n0); end
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    clear_mem();
    mem[0] = ent(8'd2, 8'd2, K_PNT);
    mem[1] = ent(8'd4, 8'd4, K_LINE);
    bus.go = 1'b1;
    wait_draw(ok);
    wait_draw(ok);
    checks++; if (bus.adrRAM !== 16'd1) begin errors++; $display("FAIL rmid_adr: got %0d expected 1", bus.adrRAM); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.start !== 1'b0 || bus.halt !== 1'b0) begin errors++; $display("FAIL rmid_drop: got start=%b halt=%b expected 0,0", bus.start, bus.halt); end
    checks++; if (bus.adrRAM !== 16'd0 || bus.x1 !== 8'd0) begin errors++; $display("FAIL rmid_clear: got adr=%0d x1=%0d expected 0,0", bus.adrRAM, bus.x1); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.halt !== 1'b1 || bus.adrRAM !== 16'd0) begin errors++; $display("FAIL rmid_refetch: got halt=%b adr=%0d expected 1,0", bus.halt, bus.adrRAM); end
    wait_draw(ok);
    bus.go = 1'b0;
    checks++; if ({bus.x0, bus.x1} !== {8'd2, 8'd2}) begin errors++; $display("FAIL rmid_first: got %0d,%0d expected 2,2", bus.x0, bus.x1); end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_frame: got timeout expected frame_done"); end
  endtask

  task automatic test_overrun();
    bit ok;
    for (int i = 0; i < 16; i++) mem2[i] = ent(8'(i), 8'(15 - i), K_LINE);
    bus2.go = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(posedge clk); #1;
        if (bus2.start) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || bus2.x1 !== 8'(i) || bus2.adrRAM !== 4'(i)) begin errors++; $display("FAIL ovr_entry%0d: got ok=%b x1=%0d adr=%0d expected 1,%0d,%0d", i, ok, bus2.x1, bus2.adrRAM, i, i); end
      if (i == 15) begin
        checks++; if (bus2.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", bus2.overrun); end
      end
      @(posedge clk); #1 done2 = 1'b1;
      @(posedge clk); #1 done2 = 1'b0;
    end
    bus2.go = 1'b0;
    checks++; if (bus2.frame_done !== 1'b1) begin errors++; $display("FAIL ovr_frame: got %b expected 1", bus2.frame_done); end
    checks++; if (bus2.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", bus2.overrun); end
    checks++; if (bus2.adrRAM !== 4'd15) begin errors++; $display("FAIL ovr_nowrap: got %0d expected 15", bus2.adrRAM); end
    @(posedge clk); #1;
    checks++; if (bus2.overrun !== 1'b1 || bus2.adrRAM !== 4'd0 || bus2.halt !== 1'b0) begin errors++; $display("FAIL ovr_after: got ovr=%b adr=%0d halt=%b expected 1,0,0", bus2.overrun, bus2.adrRAM, bus2.halt); end
  endtask

`ifdef MEMORY_READ_BLANK_MOVE_EN
  task automatic test_blank();
    bit ok;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    clear_mem();
    mem[0] = ent(8'd5, 8'd9, K_MOVE);
    mem[1] = ent(8'd6, 8'd6, K_LINE);
    bus.go = 1'b1;
    for (int n = 0; n < 2; n++) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(posedge clk); #1;
        if (bus.start) begin ok = 1'b1; break; end
      end
      bus.go = 1'b0;
      if (n == 0) begin
        checks++; if (!ok || bus.blank !== 1'b1) begin errors++; $display("FAIL blank_move: got ok=%b blank=%b expected 1,1", ok, bus.blank); end
        checks++; if ({bus.x0, bus.y0, bus.x1, bus.y1} !== {8'd0, 8'd0, 8'd5, 8'd9}) begin errors++; $display("FAIL blank_move_coords: got %0d,%0d,%0d,%0d expected 0,0,5,9", bus.x0, bus.y0, bus.x1, bus.y1); end
      end else begin
        checks++; if (!ok || bus.blank !== 1'b0) begin errors++; $display("FAIL blank_line: got ok=%b blank=%b expected 1,0", ok, bus.blank); end
        checks++; if ({bus.x0, bus.y0, bus.x1, bus.y1} !== {8'd5, 8'd9, 8'd6, 8'd6}) begin errors++; $display("FAIL blank_line_coords: got %0d,%0d,%0d,%0d expected 5,9,6,6", bus.x0, bus.y0, bus.x1, bus.y1); end
      end
    end
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL blank_frame: got timeout expected frame_done"); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    for (int i = 0; i < 16; i++) mem2[i] = ent(8'd0, 8'd0, K_END);
    test_reset();
    test_line();
    test_point();
    test_done_ignored();
    test_go_drop();
    test_reset_mid_line();
    test_overrun();
`ifdef MEMORY_READ_BLANK_MOVE_EN
    test_blank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
